// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl
// Hazard and flow controller sitting at the EX end of the ID->EX pipeline
// register. It looks at the instruction in EX (destination, load flag,
// branch resolution) and the sources decoded in ID. From these it drives the
// PC / IF->ID / ID->EX enables, the bubble/flush controls and the PC
// redirect.
//
// Ports
//   clk, rst            clock; asynchronous active-low reset
//   ex_*                instruction currently held in EX
//   id_*                source-operand usage of the instruction in ID
//   mem_busy            data memory not ready; the whole front end holds
//   pc_en, if2id_en,
//   id2ex_en            register enables (1 = register captures new data)
//   if2id_flush         IF->ID captures a bubble
//   id2ex_bubble        ID->EX captures a nop instead of the ID contents
//   pc_redirect/_addr   PC loads the corrected fetch address
//   state               current FSM state (action taken in the previous cycle)
//   stall_count,
//   flush_count         saturating load-use / mispredict event counters
//
// Flow-control contract: every control output is combinational and refers to
// the clock edge that ends the current cycle. An enable of 0 means the
// register keeps its value at that edge. flush/bubble only take effect when
// the matching enable is 1.

module ex_hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic             ex_rd_wr,
    input  logic [2:0]       ex_rd,
    input  logic             ex_is_branch,
    input  logic             ex_spec_taken,
    input  logic             ex_br_taken,
    input  logic [15:0]      ex_br_target,
    input  logic [15:0]      ex_pc_next,
    input  logic             id_valid,
    input  logic             id_use_a1,
    input  logic             id_use_a2,
    input  logic [2:0]       id_rf_a1,
    input  logic [2:0]       id_rf_a2,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             if2id_en,
    output logic             if2id_flush,
    output logic             id2ex_en,
    output logic             id2ex_bubble,
    output logic             pc_redirect,
    output logic [15:0]      pc_redirect_addr,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        FLUSH    = 2'd2,
        FREEZE   = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   stall_inc;
    logic   flush_inc;
    logic   mispredict;
    logic   load_use;

    assign state = state_q;

    // A hazard is suppressed only when the previous cycle already acted on
    // it. After FREEZE the EX instruction is still there, so it is acted on
    // at that point.
    assign mispredict = ex_valid && ex_is_branch &&
                        (ex_spec_taken != ex_br_taken) && (state_q != FLUSH);

    assign load_use = ex_valid && ex_is_load && ex_rd_wr && id_valid &&
                      (state_q != LU_STALL) &&
                      ((id_use_a1 && (id_rf_a1 == ex_rd)) ||
                       (id_use_a2 && (id_rf_a2 == ex_rd)));

    always_comb begin
        pc_en            = 1'b0;
        if2id_en         = 1'b0;
        if2id_flush      = 1'b0;
        id2ex_en         = 1'b0;
        id2ex_bubble     = 1'b0;
        pc_redirect      = 1'b0;
        pc_redirect_addr = 16'h0000;
        stall_inc        = 1'b0;
        flush_inc        = 1'b0;
        state_d          = RUN;

        // While reset is held every control stays at 0.
        if (rst) begin
            if (mem_busy) begin
                state_d = FREEZE;
            end else if (mispredict) begin
                pc_en            = 1'b1;
                if2id_en         = 1'b1;
                id2ex_en         = 1'b1;
                if2id_flush      = 1'b1;
                id2ex_bubble     = 1'b1;
                pc_redirect      = 1'b1;
                pc_redirect_addr = ex_br_taken ? ex_br_target : ex_pc_next;
                flush_inc        = 1'b1;
                state_d          = FLUSH;
            end else if (load_use) begin
                id2ex_en     = 1'b1;
                id2ex_bubble = 1'b1;
                stall_inc    = 1'b1;
                state_d      = LU_STALL;
            end else begin
                pc_en    = 1'b1;
                if2id_en = 1'b1;
                id2ex_en = 1'b1;
                state_d  = RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            state_q <= state_d;
            if (stall_inc && (stall_count != {CNT_W{1'b1}}))
                stall_count <= stall_count + CNT_W'(1);
            if (flush_inc && (flush_count != {CNT_W{1'b1}}))
                flush_count <= flush_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
module tb_ex_hazard_ctrl;

    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             ex_valid;
    logic             ex_is_load;
    logic             ex_rd_wr;
    logic [2:0]       ex_rd;
    logic             ex_is_branch;
    logic             ex_spec_taken;
    logic             ex_br_taken;
    logic [15:0]      ex_br_target;
    logic [15:0]      ex_pc_next;
    logic             id_valid;
    logic             id_use_a1;
    logic             id_use_a2;
    logic [2:0]       id_rf_a1;
    logic [2:0]       id_rf_a2;
    logic             mem_busy;
    logic             pc_en;
    logic             if2id_en;
    logic             if2id_flush;
    logic             id2ex_en;
    logic             id2ex_bubble;
    logic             pc_redirect;
    logic [15:0]      pc_redirect_addr;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    int tests_run = 0;
    int tests_failed = 0;

    ex_hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst              (rst),
        .ex_valid         (ex_valid),
        .ex_is_load       (ex_is_load),
        .ex_rd_wr         (ex_rd_wr),
        .ex_rd            (ex_rd),
        .ex_is_branch     (ex_is_branch),
        .ex_spec_taken    (ex_spec_taken),
        .ex_br_taken      (ex_br_taken),
        .ex_br_target     (ex_br_target),
        .ex_pc_next       (ex_pc_next),
        .id_valid         (id_valid),
        .id_use_a1        (id_use_a1),
        .id_use_a2        (id_use_a2),
        .id_rf_a1         (id_rf_a1),
        .id_rf_a2         (id_rf_a2),
        .mem_busy         (mem_busy),
        .pc_en            (pc_en),
        .if2id_en         (if2id_en),
        .if2id_flush      (if2id_flush),
        .id2ex_en         (id2ex_en),
        .id2ex_bubble     (id2ex_bubble),
        .pc_redirect      (pc_redirect),
        .pc_redirect_addr (pc_redirect_addr),
        .state            (state),
        .stall_count      (stall_count),
        .flush_count      (flush_count)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packs {pc_en, if2id_en, id2ex_en, if2id_flush, id2ex_bubble, pc_redirect}
    function automatic logic [5:0] ctl();
        return {pc_en, if2id_en, id2ex_en, if2id_flush, id2ex_bubble, pc_redirect};
    endfunction

    task automatic idle_inputs();
        ex_valid = 0; ex_is_load = 0; ex_rd_wr = 0; ex_rd = 0;
        ex_is_branch = 0; ex_spec_taken = 0; ex_br_taken = 0;
        ex_br_target = 0; ex_pc_next = 0;
        id_valid = 0; id_use_a1 = 0; id_use_a2 = 0; id_rf_a1 = 0; id_rf_a2 = 0;
        mem_busy = 0;
    endtask

    task automatic drive_load_use(input logic [2:0] rd, input logic via_a1);
        idle_inputs();
        ex_valid = 1; ex_is_load = 1; ex_rd_wr = 1; ex_rd = rd;
        id_valid = 1;
        if (via_a1) begin id_use_a1 = 1; id_rf_a1 = rd; id_rf_a2 = rd + 3'd1; end
        else        begin id_use_a2 = 1; id_rf_a2 = rd; id_rf_a1 = rd + 3'd1; end
    endtask

    task automatic drive_branch(input logic spec, input logic taken,
                                input logic [15:0] tgt, input logic [15:0] nxt);
        idle_inputs();
        ex_valid = 1; ex_is_branch = 1; ex_spec_taken = spec; ex_br_taken = taken;
        ex_br_target = tgt; ex_pc_next = nxt;
    endtask

    // Advance past the next posedge; inputs change and registers are read here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Comb outputs are checked at the falling edge.
    task automatic mid();
        @(negedge clk);
    endtask

    initial begin
        idle_inputs();
        rst = 0;

        // Reset state
        #2;
        chk("rst_ctl", 32'(ctl()), 32'h0);
        chk("rst_addr", 32'(pc_redirect_addr), 32'h0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_cnts", {stall_count, flush_count}, 32'h0);
        step();
        rst = 1;
        mid();
        chk("run_ctl", 32'(ctl()), 32'b111000);

        // Load-use: load r3, ID reads r3 via A2
        step();
        drive_load_use(3'd3, 1'b0);
        mid();
        chk("lu_ctl", 32'(ctl()), 32'b001010);
        step();
        chk("lu_state", 32'(state), 32'd1);
        chk("lu_scnt", 32'(stall_count), 32'd1);
        // Same load still in EX while in LU_STALL: not acted on again
        mid();
        chk("lu_suppr_ctl", 32'(ctl()), 32'b111000);
        idle_inputs();
        mid();
        chk("lu_after_ctl", 32'(ctl()), 32'b111000);
        step();
        chk("lu_after_state", 32'(state), 32'd0);
        chk("lu_after_scnt", 32'(stall_count), 32'd1);

        // Mispredict: predicted not taken, actually taken to 0x0040
        drive_branch(1'b0, 1'b1, 16'h0040, 16'h0022);
        mid();
        chk("mp1_ctl", 32'(ctl()), 32'b111111);
        chk("mp1_addr", 32'(pc_redirect_addr), 32'h0040);
        step();
        chk("mp1_state", 32'(state), 32'd2);
        chk("mp1_fcnt", 32'(flush_count), 32'd1);
        mid();
        chk("mp1_suppr_ctl", 32'(ctl()), 32'b111000);
        chk("mp1_suppr_addr", 32'(pc_redirect_addr), 32'h0);
        step();
        chk("mp1_suppr_fcnt", 32'(flush_count), 32'd1);

        // Mispredict: predicted taken, actually not taken -> fall-through
        drive_branch(1'b1, 1'b0, 16'h0080, 16'h0011);
        mid();
        chk("mp2_addr", 32'(pc_redirect_addr), 32'h0011);
        step();
        chk("mp2_fcnt", 32'(flush_count), 32'd2);
        idle_inputs();
        step();

        // Correct prediction: nothing happens
        drive_branch(1'b1, 1'b1, 16'h0100, 16'h0033);
        mid();
        chk("ok_ctl", 32'(ctl()), 32'b111000);
        chk("ok_addr", 32'(pc_redirect_addr), 32'h0);
        step();
        chk("ok_fcnt", 32'(flush_count), 32'd2);
        chk("ok_state", 32'(state), 32'd0);

        // Freeze for 3 cycles with a mispredicting branch in EX
        drive_branch(1'b0, 1'b1, 16'h0200, 16'h0044);
        mem_busy = 1;
        for (int i = 0; i < 3; i++) begin
            mid();
            chk("frz_ctl", 32'(ctl()), 32'b000000);
            step();
            chk("frz_state", 32'(state), 32'd3);
            chk("frz_fcnt", 32'(flush_count), 32'd2);
        end
        mem_busy = 0;
        mid();
        chk("frz_rel_ctl", 32'(ctl()), 32'b111111);
        chk("frz_rel_addr", 32'(pc_redirect_addr), 32'h0200);
        step();
        chk("frz_rel_fcnt", 32'(flush_count), 32'd3);
        chk("frz_rel_state", 32'(state), 32'd2);
        idle_inputs();
        step();

        // Mispredict and load-use together: mispredict wins, no stall counted
        drive_load_use(3'd5, 1'b1);
        ex_is_branch = 1; ex_spec_taken = 1; ex_br_taken = 0; ex_pc_next = 16'h0055;
        mid();
        chk("both_ctl", 32'(ctl()), 32'b111111);
        chk("both_addr", 32'(pc_redirect_addr), 32'h0055);
        step();
        chk("both_scnt", 32'(stall_count), 32'd1);
        chk("both_fcnt", 32'(flush_count), 32'd4);
        idle_inputs();
        step();

        // Load-use on r0 via A1 stalls normally
        drive_load_use(3'd0, 1'b1);
        mid();
        chk("r0_ctl", 32'(ctl()), 32'b001010);
        step();
        chk("r0_scnt", 32'(stall_count), 32'd2);
        idle_inputs();
        step();

        // Flush counter saturation: 11 more mispredicts reach 15, then hold
        for (int i = 0; i < 11; i++) begin
            drive_branch(1'b0, 1'b1, 16'h0300, 16'h0066);
            step();
            idle_inputs();
            step();
        end
        chk("sat_full", 32'(flush_count), 32'hF);
        drive_branch(1'b0, 1'b1, 16'h0300, 16'h0066);
        mid();
        chk("sat_ctl", 32'(ctl()), 32'b111111);
        step();
        chk("sat_hold", 32'(flush_count), 32'hF);
        idle_inputs();
        step();

        // Asynchronous reset in the middle of LU_STALL
        drive_load_use(3'd6, 1'b0);
        step();
        chk("arst_pre_state", 32'(state), 32'd1);
        #2;
        rst = 0;
        #1;
        chk("arst_ctl", 32'(ctl()), 32'h0);
        chk("arst_state", 32'(state), 32'd0);
        chk("arst_cnts", {stall_count, flush_count}, 32'h0);
        idle_inputs();
        step();
        rst = 1;
        mid();
        chk("arst_rel_ctl", 32'(ctl()), 32'b111000);
        chk("arst_rel_addr", 32'(pc_redirect_addr), 32'h0);
        step();
        chk("arst_rel_state", 32'(state), 32'd0);
        chk("arst_rel_cnts", {stall_count, flush_count}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
